barrel_shifter_pipe: RTL and testbench
======================================

Name: barrel_shifter_pipe

Overview:
Parametrised, pipelined, multi-mode successor to the single-cycle left barrel shifter used in the compression datapath (Stage1+2+3). It supports logical shift left, logical shift right, rotate left and arithmetic shift right. Pipeline registers are inserted between shift stages at a configurable spacing, and beats move under a valid/ready handshake with full backpressure. A sideband tag travels with each beat so compressor packing logic can re-associate results.

Parameters:
- WIDTH, 68, data word width in bits (>= 2).
- SHIFT_BIT, 7, shift-amount width; the shifter has SHIFT_BIT stages, and stage k shifts by 2^k.
- STAGES_PER_REG, 2, shift stages between pipeline registers (1..SHIFT_BIT).
- TAG_W, 4, sideband tag width.
- Derived: N_REG = ceil(SHIFT_BIT / STAGES_PER_REG), the pipeline depth in cycles.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  block can accept a beat this cycle.
- i_word  in  WIDTH  operand.
- i_amt  in  SHIFT_BIT  shift amount, unsigned.
- i_mode  in  2  00=SLL, 01=SRL, 10=ROL, 11=SRA.
- i_tag  in  TAG_W  sideband, passed through unchanged.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_word  out  WIDTH  result.
- o_tag  out  TAG_W  tag of the result beat.

Behaviour:
- Reset, synchronous, active-high: clears all N_REG valid bits and zeroes all data, tag and mode registers.
  - After reset: o_valid=0, o_word=0, o_tag=0, o_ready=1.
  - Reset mid-stream discards every in-flight beat. No partial beat ever appears on the output.
- Handshake:
  - A beat is accepted when i_valid && o_ready.
  - A beat is consumed when o_valid && i_ready.
  - While o_valid=1 and i_ready=0, o_word and o_tag hold stable.
- Pipeline: N_REG register slots, each with its own valid bit.
  - Slot j loads when it is empty or slot j+1 loads (or, for the last slot, when the output is consumed).
  - o_ready = slot0 loads-enable. This is a combinational chain from i_ready; no combinational path from i_valid to o_ready.
  - Bubbles collapse: an empty slot loads even when downstream is stalled.
- Latency and throughput:
  - With no stall, a beat accepted in cycle t gives o_valid in cycle t+N_REG (4 at defaults).
  - Throughput is 1 beat/cycle.
  - Capacity is N_REG beats.
  - Order is strictly preserved.
- Per-stage operation (stage k, amt bit k set):
  - SLL: shift left 2^k, zero fill.
  - SRL: shift right 2^k, zero fill.
  - SRA: shift right 2^k, fill with the operand MSB captured at accept.
  - ROL: rotate left by (2^k mod WIDTH). The overall rotate is therefore by (i_amt mod WIDTH).
  - Stages where 2^k >= WIDTH: SLL and SRL give all-zero; SRA gives all-sign.
  - The mode and unconsumed amount bits are carried in pipeline registers with each beat.
- Boundaries:
  - i_amt=0 returns i_word unchanged in all modes.
  - i_amt >= WIDTH: SLL/SRL give 0; SRA gives {WIDTH{msb}}; ROL wraps as above.
  - Full pipeline with i_ready=0: o_ready=0 and input is ignored.
  - Simultaneous accept and consume on a full pipeline is legal and keeps occupancy constant.

Optional Feature:
- Macro: BARREL_SHIFTER_PIPE_LOST_EN.
- When defined:
  - Adds output o_lost (1 bit), registered and aligned with o_word.
  - o_lost is set when any 1-bit was shifted out in SLL or SRL, or when any bit different from the sign was shifted out in SRA.
  - o_lost is always 0 for ROL.
  - o_lost resets to 0.
  - Compressors use it to detect overflowing packing offsets.
- When undefined: the port and its logic are absent.

Test Plan:
1. Defaults, SLL, i_word=1, i_amt=67, tag=3, i_ready=1 -> 4 cycles later o_word=68'h8_0000_0000_0000_0000, o_tag=3.
2. SRA, i_word=68'h8_0000_0000_0000_0000, i_amt=4 -> o_word=68'hF_8000_0000_0000_0000. Same operand with SRL -> 68'h0_8000_0000_0000_0000.
3. Mode sweep at amt >= WIDTH, i_word=68'hF_0000_0000_0000_0001:
   - SLL, amt=100 -> 0.
   - SRA, amt=127 -> all ones.
   - ROL, amt=70 -> 68'hC_0000_0000_0000_0007 (equal to ROL by 2).
4. Backpressure: stream 8 beats with tags 0..7 and hold i_ready=0 for 6 cycles -> o_ready drops after 4 accepts, o_word/o_tag stable during the stall, all 8 tags emerge in order 0..7 with correct data and no duplicates.
5. Reset mid-stream: 3 beats in flight, assert i_reset 1 cycle -> next cycle o_valid=0, o_word=0, o_ready=1. A subsequent beat SLL 1 by 1 yields 2 after 4 cycles.
6. With BARREL_SHIFTER_PIPE_LOST_EN:
   - SLL, i_word=68'h8_0000_0000_0000_0000, amt=1 -> o_word=0, o_lost=1.
   - ROL, same inputs -> o_word=1, o_lost=0.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined multi-mode barrel shifter (SLL, SRL, ROL, SRA)
// with valid/ready handshake, full backpressure and a sideband tag per beat.
// Shift stage k moves the word by 2^k; STAGES_PER_REG stages sit between
// pipeline registers, giving N_REG = ceil(SHIFT_BIT / STAGES_PER_REG) cycles
// of latency.
// Optional build macro BARREL_SHIFTER_PIPE_LOST_EN adds o_lost, which flags
// significant bits shifted out of the word.
module barrel_shifter_pipe #(
    parameter int WIDTH          = 68,
    parameter int SHIFT_BIT      = 7,
    parameter int STAGES_PER_REG = 2,
    parameter int TAG_W          = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_word,
    input  logic [SHIFT_BIT-1:0] i_amt,
    input  logic [1:0]           i_mode,
    input  logic [TAG_W-1:0]     i_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_word,
`ifdef BARREL_SHIFTER_PIPE_LOST_EN
    output logic                 o_lost,
`endif
    output logic [TAG_W-1:0]     o_tag
);

    localparam int N_REG = (SHIFT_BIT + STAGES_PER_REG - 1) / STAGES_PER_REG;
    // The last slot no longer needs amount/mode/sign, so only N_REG-1 slots carry them.
    localparam int N_CTL = (N_REG > 1) ? N_REG - 1 : 1;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b11;

    // One shift stage of weight 2^k. Stages wider than the word saturate
    // (zero or sign); rotates reduce the weight modulo WIDTH.
    function automatic logic [WIDTH-1:0] stage_op(input logic [WIDTH-1:0] d, input int k,
                                                  input logic [1:0] mode, input logic sign);
        int               sh;
        int               rot;
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] r;
        sh   = 1 << k;
        rot  = sh % WIDTH;
        fill = {WIDTH{sign}};
        case (mode)
            MODE_SLL: r = (sh >= WIDTH) ? '0 : (d << sh);
            MODE_SRL: r = (sh >= WIDTH) ? '0 : (d >> sh);
            MODE_SRA: r = (sh >= WIDTH) ? fill : ((d >> sh) | (fill & ~({WIDTH{1'b1}} >> sh)));
            default:  r = (rot == 0) ? d : ((d << rot) | (d >> (WIDTH - rot)));
        endcase
        return r;
    endfunction

    // Applies every stage that belongs to pipeline slot 'slot'.
    function automatic logic [WIDTH-1:0] slot_shift(input logic [WIDTH-1:0] d,
                                                    input logic [SHIFT_BIT-1:0] amt,
                                                    input logic [1:0] mode, input logic sign,
                                                    input int slot);
        logic [WIDTH-1:0] r;
        r = d;
        for (int k = 0; k < SHIFT_BIT; k++) begin
            if (((k / STAGES_PER_REG) == slot) && amt[k]) r = stage_op(r, k, mode, sign);
        end
        return r;
    endfunction

`ifdef BARREL_SHIFTER_PIPE_LOST_EN
    // True when the stage drops a 1 (logical) or a non-sign bit (arithmetic).
    function automatic logic stage_lost(input logic [WIDTH-1:0] d, input int k,
                                        input logic [1:0] mode, input logic sign);
        int               sh;
        logic [WIDTH-1:0] x;
        logic             l;
        sh = 1 << k;
        x  = (mode == MODE_SRA) ? (d ^ {WIDTH{sign}}) : d;
        case (mode)
            MODE_SLL:           l = (sh >= WIDTH) ? |x : |(x >> (WIDTH - sh));
            MODE_SRL, MODE_SRA: l = (sh >= WIDTH) ? |x : |(x << (WIDTH - sh));
            default:            l = 1'b0;
        endcase
        return l;
    endfunction

    function automatic logic slot_lost(input logic [WIDTH-1:0] d,
                                       input logic [SHIFT_BIT-1:0] amt,
                                       input logic [1:0] mode, input logic sign,
                                       input int slot);
        logic [WIDTH-1:0] r;
        logic             l;
        r = d;
        l = 1'b0;
        for (int k = 0; k < SHIFT_BIT; k++) begin
            if (((k / STAGES_PER_REG) == slot) && amt[k]) begin
                l = l | stage_lost(r, k, mode, sign);
                r = stage_op(r, k, mode, sign);
            end
        end
        return l;
    endfunction
`endif

    logic [N_REG-1:0]     vld_q;
    logic [WIDTH-1:0]     data_q [N_REG];
    logic [TAG_W-1:0]     tag_q  [N_REG];
    logic [SHIFT_BIT-1:0] amt_q  [N_CTL];
    logic [1:0]           mode_q [N_CTL];
    logic [N_CTL-1:0]     sign_q;

    logic [N_REG-1:0]     ld;
    logic [N_REG-1:0]     vin;
    logic [N_REG-1:0]     sign_in;
    logic [WIDTH-1:0]     din    [N_REG];
    logic [WIDTH-1:0]     dnext  [N_REG];
    logic [TAG_W-1:0]     tag_in [N_REG];
    logic [SHIFT_BIT-1:0] amt_in [N_REG];
    logic [1:0]           mode_in[N_REG];

`ifdef BARREL_SHIFTER_PIPE_LOST_EN
    logic [N_REG-1:0]     lost_q;
    logic [N_REG-1:0]     lost_in;
    logic [N_REG-1:0]     lost_next;
`endif

    // Slot j loads unless it and every slot after it are full and the output is stalled.
    always_comb begin
        ld = '0;
        for (int j = 0; j < N_REG; j++) begin
            ld[j] = i_ready | ~(&(vld_q | ~({N_REG{1'b1}} << j)));
        end
    end

    // Select what feeds each slot: the upstream port for slot 0, the previous slot otherwise.
    always_comb begin
        vin        = '0;
        sign_in    = '0;
        din[0]     = i_word;
        tag_in[0]  = i_tag;
        amt_in[0]  = i_amt;
        mode_in[0] = i_mode;
        vin[0]     = i_valid;
        sign_in[0] = i_word[WIDTH-1];
        for (int j = 1; j < N_REG; j++) begin
            din[j]     = data_q[j-1];
            tag_in[j]  = tag_q[j-1];
            amt_in[j]  = amt_q[j-1];
            mode_in[j] = mode_q[j-1];
            vin[j]     = vld_q[j-1];
            sign_in[j] = sign_q[j-1];
        end
    end

    // Shift logic for each slot's group of stages.
    always_comb begin
        for (int j = 0; j < N_REG; j++) begin
            dnext[j] = slot_shift(din[j], amt_in[j], mode_in[j], sign_in[j], j);
        end
    end

`ifdef BARREL_SHIFTER_PIPE_LOST_EN
    // Lost flag accumulates across slots alongside the data.
    always_comb begin
        lost_in   = '0;
        lost_next = '0;
        for (int j = 1; j < N_REG; j++) lost_in[j] = lost_q[j-1];
        for (int j = 0; j < N_REG; j++) begin
            lost_next[j] = lost_in[j] | slot_lost(din[j], amt_in[j], mode_in[j], sign_in[j], j);
        end
    end
`endif

    // Pipeline registers: a slot takes a new beat (or a bubble) whenever it loads.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_q  <= '0;
            sign_q <= '0;
`ifdef BARREL_SHIFTER_PIPE_LOST_EN
            lost_q <= '0;
`endif
            for (int j = 0; j < N_REG; j++) begin
                data_q[j] <= '0;
                tag_q[j]  <= '0;
            end
            for (int j = 0; j < N_CTL; j++) begin
                amt_q[j]  <= '0;
                mode_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < N_REG; j++) begin
                if (ld[j]) begin
                    vld_q[j] <= vin[j];
                    if (vin[j]) begin
                        data_q[j] <= dnext[j];
                        tag_q[j]  <= tag_in[j];
`ifdef BARREL_SHIFTER_PIPE_LOST_EN
                        lost_q[j] <= lost_next[j];
`endif
                    end
                end
            end
            for (int j = 0; j < N_REG - 1; j++) begin
                if (ld[j] && vin[j]) begin
                    amt_q[j]  <= amt_in[j];
                    mode_q[j] <= mode_in[j];
                    sign_q[j] <= sign_in[j];
                end
            end
        end
    end

    assign o_ready = ld[0];
    assign o_valid = vld_q[N_REG-1];
    assign o_word  = data_q[N_REG-1];
    assign o_tag   = tag_q[N_REG-1];
`ifdef BARREL_SHIFTER_PIPE_LOST_EN
    assign o_lost  = lost_q[N_REG-1];
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe: the driver pushes the expected
// result of every accepted beat, and a monitor pops and compares each beat
// the DUT hands downstream.
module tb_barrel_shifter_pipe;

    localparam int WIDTH = 68;
    localparam int SHIFT_BIT = 7;
    localparam int TAG_W = 4;
    localparam int N_REG = 4;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] ROL = 2'b10;
    localparam logic [1:0] SRA = 2'b11;

    logic                 i_clk = 1'b0;
    logic                 i_reset;
    logic                 i_valid;
    logic                 o_ready;
    logic [WIDTH-1:0]     i_word;
    logic [SHIFT_BIT-1:0] i_amt;
    logic [1:0]           i_mode;
    logic [TAG_W-1:0]     i_tag;
    logic                 o_valid;
    logic                 i_ready;
    logic [WIDTH-1:0]     o_word;
    logic [TAG_W-1:0]     o_tag;
`ifdef BARREL_SHIFTER_PIPE_LOST_EN
    logic                 o_lost;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic [TAG_W-1:0] tag;
        logic             lost;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_acc = 0;
    bit   rand_done = 0;

    barrel_shifter_pipe dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_word  (i_word),
        .i_amt   (i_amt),
        .i_mode  (i_mode),
        .i_tag   (i_tag),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_word  (o_word),
`ifdef BARREL_SHIFTER_PIPE_LOST_EN
        .o_lost  (o_lost),
`endif
        .o_tag   (o_tag)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input bit ok, input string name,
                         input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference: the whole shift computed at once from the amount.
    function automatic logic [WIDTH-1:0] model_word(input logic [WIDTH-1:0] w,
                                                    input int a, input logic [1:0] mode);
        int r;
        case (mode)
            SLL: return (a >= WIDTH) ? '0 : (w << a);
            SRL: return (a >= WIDTH) ? '0 : (w >> a);
            SRA: return (a >= WIDTH) ? {WIDTH{w[WIDTH-1]}} : WIDTH'($signed(w) >>> a);
            default: begin
                r = a % WIDTH;
                return (r == 0) ? w : ((w << r) | (w >> (WIDTH - r)));
            end
        endcase
    endfunction

    function automatic logic model_lost(input logic [WIDTH-1:0] w,
                                        input int a, input logic [1:0] mode);
        logic [WIDTH-1:0] x;
        x = w ^ {WIDTH{w[WIDTH-1]}};
        case (mode)
            SLL: return (a >= WIDTH) ? (w != '0) : ((w >> (WIDTH - a)) != '0);
            SRL: return (a >= WIDTH) ? (w != '0) : ((w << (WIDTH - a)) != '0);
            SRA: return (a >= WIDTH) ? (x != '0) : ((x << (WIDTH - a)) != '0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic send(input logic [WIDTH-1:0] w, input logic [SHIFT_BIT-1:0] amt,
                        input logic [1:0] mode, input logic [TAG_W-1:0] tag,
                        input logic [WIDTH-1:0] ew, input logic el);
        bit done = 0;
        int guard = 0;
        while (!done) begin
            @(negedge i_clk);
            i_valid = 1'b1;
            i_word  = w;
            i_amt   = amt;
            i_mode  = mode;
            i_tag   = tag;
            #1;
            if (o_ready) begin
                sb.push_back('{word: ew, tag: tag, lost: el});
                n_acc++;
                done = 1;
            end
            @(posedge i_clk);
            guard++;
            if (!done && guard > 1000) begin
                check(1'b0, "send_timeout", WIDTH'(guard), '0);
                done = 1;
            end
        end
    endtask

    task automatic send_model(input logic [WIDTH-1:0] w, input logic [SHIFT_BIT-1:0] amt,
                              input logic [1:0] mode, input logic [TAG_W-1:0] tag);
        send(w, amt, mode, tag, model_word(w, int'(amt), mode), model_lost(w, int'(amt), mode));
    endtask

    task automatic send_rand(input logic [TAG_W-1:0] tag);
        logic [95:0]          t;
        logic [SHIFT_BIT-1:0] a;
        logic [1:0]           m;
        t = {$urandom(), $urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0:       a = '0;
            1:       a = SHIFT_BIT'($urandom_range(64, 72));
            default: a = SHIFT_BIT'($urandom_range(0, 127));
        endcase
        m = 2'($urandom_range(0, 3));
        send_model(t[WIDTH-1:0], a, m, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_valid = 1'b0;
        end
    endtask

    // Cycles from the accepting edge until the beat shows up at the output.
    task automatic latency(input string name);
        int c;
        for (c = 1; c <= 20; c++) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            #2;
            if (o_valid) break;
        end
        check(c == N_REG, name, WIDTH'(c), WIDTH'(N_REG));
    endtask

    task automatic drain(input string name);
        int g = 0;
        @(negedge i_clk);
        i_valid = 1'b0;
        while (sb.size() != 0 && g < 500) begin
            @(negedge i_clk);
            g++;
        end
        check(sb.size() == 0, name, WIDTH'(sb.size()), '0);
    endtask

    // Monitor: compares each consumed beat and checks output hold during stalls.
    initial begin
        exp_t             e;
        bit               prev_stall = 0;
        logic [WIDTH-1:0] pw = '0;
        logic [TAG_W-1:0] pt = '0;
        forever begin
            @(negedge i_clk);
            #2;
            if (i_reset || !o_valid) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check(o_word == pw, "stall_hold_word", o_word, pw);
                    check(o_tag == pt, "stall_hold_tag", WIDTH'(o_tag), WIDTH'(pt));
                end
                if (i_ready) begin
                    prev_stall = 0;
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_beat", o_word, '0);
                    end else begin
                        e = sb.pop_front();
                        check(o_word == e.word, "word", o_word, e.word);
                        check(o_tag == e.tag, "tag", WIDTH'(o_tag), WIDTH'(e.tag));
`ifdef BARREL_SHIFTER_PIPE_LOST_EN
                        check(o_lost == e.lost, "lost", WIDTH'(o_lost), WIDTH'(e.lost));
`endif
                    end
                end else begin
                    prev_stall = 1;
                    pw = o_word;
                    pt = o_tag;
                end
            end
        end
    end

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_word  = '0;
        i_amt   = '0;
        i_mode  = '0;
        i_tag   = '0;
        i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        #2;
        check(o_valid == 1'b0, "reset_o_valid", WIDTH'(o_valid), '0);
        check(o_word == '0, "reset_o_word", o_word, '0);
        check(o_tag == '0, "reset_o_tag", WIDTH'(o_tag), '0);
        check(o_ready == 1'b1, "reset_o_ready", WIDTH'(o_ready), WIDTH'(1));

        // SLL 1 by 67 and the pipeline latency
        send(68'h1, 7'd67, SLL, 4'd3, 68'h8_0000_0000_0000_0000, 1'b0);
        latency("latency_sll67");
        drain("drain_sll67");

        // SRA vs SRL of an MSB-only word
        send(68'h8_0000_0000_0000_0000, 7'd4, SRA, 4'd1, 68'hF_8000_0000_0000_0000, 1'b0);
        send(68'h8_0000_0000_0000_0000, 7'd4, SRL, 4'd2, 68'h0_8000_0000_0000_0000, 1'b0);
        // amounts at or beyond the word width
        send(68'hF_0000_0000_0000_0001, 7'd100, SLL, 4'd4, 68'h0, 1'b1);
        send(68'hF_0000_0000_0000_0001, 7'd127, SRA, 4'd5, {WIDTH{1'b1}}, 1'b1);
        send(68'hF_0000_0000_0000_0001, 7'd70, ROL, 4'd6, 68'hC_0000_0000_0000_0007, 1'b0);
        send(68'h1_2345_6789_ABCD_EF01, 7'd0, SRA, 4'd7, 68'h1_2345_6789_ABCD_EF01, 1'b0);
        send(68'h1_2345_6789_ABCD_EF01, 7'd68, ROL, 4'd8, 68'h1_2345_6789_ABCD_EF01, 1'b0);
        drain("drain_directed");

        // backpressure: 8 beats while downstream stalls for 6 cycles
        @(negedge i_clk);
        i_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                for (int t = 0; t < 8; t++) send_rand(TAG_W'(t));
            end
            begin
                repeat (6) @(negedge i_clk);
                check(n_acc == N_REG, "stall_accepts", WIDTH'(n_acc), WIDTH'(N_REG));
                check(o_ready == 1'b0, "stall_o_ready", WIDTH'(o_ready), '0);
                i_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // reset with beats in flight
        for (int t = 0; t < 3; t++) send_rand(TAG_W'(t + 9));
        @(negedge i_clk);
        i_valid = 1'b0;
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        sb.delete();
        #2;
        check(o_valid == 1'b0, "midreset_o_valid", WIDTH'(o_valid), '0);
        check(o_word == '0, "midreset_o_word", o_word, '0);
        check(o_ready == 1'b1, "midreset_o_ready", WIDTH'(o_ready), WIDTH'(1));
        send(68'h1, 7'd1, SLL, 4'd12, 68'h2, 1'b0);
        latency("latency_after_reset");
        drain("drain_after_reset");

`ifdef BARREL_SHIFTER_PIPE_LOST_EN
        send(68'h8_0000_0000_0000_0000, 7'd1, SLL, 4'd13, 68'h0, 1'b1);
        send(68'h8_0000_0000_0000_0000, 7'd1, ROL, 4'd14, 68'h1, 1'b0);
        drain("drain_lost");
`endif

        // random traffic with random downstream stalls and input gaps
        rand_done = 0;
        fork
            begin
                for (int t = 0; t < 300; t++) begin
                    send_rand(TAG_W'(t));
                    if ($urandom_range(0, 4) == 0) idle(1);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(negedge i_clk);
                    i_ready = ($urandom_range(0, 3) != 0);
                end
                i_ready = 1'b1;
            end
        join
        drain("drain_random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
